// File: rtl/lsu_mem_ctrl_if.sv
// Request/response handshake and data_mem port bundle for lsu_mem_ctrl.
// slave = controller view, master = execute-stage / memory side view.
interface lsu_mem_ctrl_if;
    logic        req_valid_in;
    logic        req_ready_out;
    logic        is_store_in;
    logic [2:0]  funct3_in;
    logic [31:0] addr_in;
    logic [31:0] wdata_in;
    logic        resp_valid_out;
    logic [31:0] rdata_out;
    logic        err_out;
    logic        mem_load_en_out;
    logic        mem_store_en_out;
    logic [31:0] mem_addr_out;
    logic [31:0] mem_store_data_out;
    logic [31:0] mem_data_in;

    modport slave (
        input  req_valid_in, is_store_in, funct3_in, addr_in, wdata_in, mem_data_in,
        output req_ready_out, resp_valid_out, rdata_out, err_out,
               mem_load_en_out, mem_store_en_out, mem_addr_out, mem_store_data_out
    );

    modport master (
        output req_valid_in, is_store_in, funct3_in, addr_in, wdata_in, mem_data_in,
        input  req_ready_out, resp_valid_out, rdata_out, err_out,
               mem_load_en_out, mem_store_en_out, mem_addr_out, mem_store_data_out
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV32I load/store controller in front of a word-wide data_mem; sub-word stores use read-modify-write.
// Latency from accept edge: LW/LB/LH 2, SW 1, SB/SH 3, error 1. Optional MISALIGN_TRAP_EN traps misaligned accesses.
// Backpressure: req_ready_out only in IDLE, one request in flight; a response cycle may accept the next request.
module lsu_mem_ctrl #(
    parameter int DEPTH_WORDS = 1024
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    lsu_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_WR,
        S_ERR
    } state_t;

    state_t      state;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] wbuf;
    logic [31:0] rdata_q;
    logic        resp_valid_q;
    logic        err_q;
    logic        req_bad;
    logic        accept;

    // Word index is passed through unchecked; the depth only documents the attached RAM.
    logic unused_depth;
    assign unused_depth = (DEPTH_WORDS > 0);

    assign accept = bus.req_valid_in & bus.req_ready_out;

    always_comb begin
        req_bad = 1'b0;
        if (bus.is_store_in) begin
            req_bad = bus.funct3_in[2] | (bus.funct3_in[1:0] == 2'b11);
        end else begin
            req_bad = (bus.funct3_in == 3'b011) | (bus.funct3_in[2:1] == 2'b11);
        end
`ifdef MISALIGN_TRAP_EN
        if ((bus.funct3_in[1:0] == 2'b01) && bus.addr_in[0]) begin
            req_bad = 1'b1;
        end
        if ((bus.funct3_in[1:0] == 2'b10) && (bus.addr_in[1:0] != 2'b00)) begin
            req_bad = 1'b1;
        end
`endif
    end

    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  a,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            default: r = w;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                                input logic [1:0]  a,
                                                input logic [31:0] old,
                                                input logic [31:0] wd);
        logic [31:0] m;
        m = old;
        if (f3[1:0] == 2'b00) begin
            case (a)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else if (a[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        return m;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state        <= S_IDLE;
            is_store_q   <= 1'b0;
            funct3_q     <= 3'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            wbuf         <= 32'd0;
            rdata_q      <= 32'd0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        is_store_q <= bus.is_store_in;
                        funct3_q   <= bus.funct3_in;
                        addr_q     <= bus.addr_in;
                        wdata_q    <= bus.wdata_in;
                        if (req_bad) begin
                            state <= S_ERR;
                        end else if (bus.is_store_in && (bus.funct3_in[1:0] == 2'b10)) begin
                            state <= S_WR;
                        end else begin
                            state <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Sub-word stores pick up the old word here and finish in WR.
                    if (is_store_q) begin
                        wbuf  <= store_merge(funct3_q, addr_q[1:0], bus.mem_data_in, wdata_q);
                        state <= S_WR;
                    end else begin
                        rdata_q      <= load_extract(funct3_q, addr_q[1:0], bus.mem_data_in);
                        resp_valid_q <= 1'b1;
                        state        <= S_IDLE;
                    end
                end
                S_WR: begin
                    resp_valid_q <= 1'b1;
                    state        <= S_IDLE;
                end
                S_ERR: begin
                    resp_valid_q <= 1'b1;
                    err_q        <= 1'b1;
                    rdata_q      <= 32'd0;
                    state        <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Enables decode straight from state so an async reset kills a pending write at once.
    assign bus.req_ready_out      = (state == S_IDLE);
    assign bus.mem_load_en_out    = (state == S_RD);
    assign bus.mem_store_en_out   = (state == S_WR);
    assign bus.mem_addr_out       = {2'b00, addr_q[31:2]};
    assign bus.mem_store_data_out = (funct3_q[1:0] == 2'b10) ? wdata_q : wbuf;
    assign bus.resp_valid_out     = resp_valid_q;
    assign bus.err_out            = err_q;
    assign bus.rdata_out          = rdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Scoreboard bench for lsu_mem_ctrl with a behavioural word RAM standing in for data_mem.
module tb_lsu_mem_ctrl;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_tests;
    int   n_fail;
    int   st_cnt;
    int   ld_cnt;
    logic [31:0] last_waddr;
    logic [31:0] last_wdata;
    logic [31:0] mem     [64];
    logic [31:0] ref_mem [64];
    logic [31:0] ref_rdata;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          c0;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl #(.DEPTH_WORDS(1024)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (bus.mem_store_en_out) mem[bus.mem_addr_out[5:0]] <= bus.mem_store_data_out;
        if (bus.mem_load_en_out)  bus.mem_data_in <= mem[bus.mem_addr_out[5:0]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (bus.mem_store_en_out) begin
                st_cnt++;
                last_waddr = bus.mem_addr_out;
                last_wdata = bus.mem_store_data_out;
            end
            if (bus.mem_load_en_out) ld_cnt++;
            if (bus.resp_valid_out) begin
                if (exp_q.size() == 0) begin
                    check("spurious_resp", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("err", {31'd0, bus.err_out}, {31'd0, e.err});
                    check("rdata", bus.rdata_out, e.rdata);
                    check("latency", 32'(cyc - e.c0), 32'(e.lat));
                end
            end
        end
    end

    task automatic issue(input bit st, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        int          n;
        bit          bad;
        logic [31:0] w;
        logic [7:0]  b8;
        logic [15:0] h16;
        @(negedge clk);
        bus.req_valid_in = 1'b1;
        bus.is_store_in  = st;
        bus.funct3_in    = f3;
        bus.addr_in      = a;
        bus.wdata_in     = wd;
        n = 0;
        while (!bus.req_ready_out && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready_out) begin
            check("accept_timeout", 32'd0, 32'd1);
            bus.req_valid_in = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.req_valid_in = 1'b0;
        bad = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
`ifdef MISALIGN_TRAP_EN
        if (f3[1:0] == 2'b01 && a[0]) bad = 1'b1;
        if (f3[1:0] == 2'b10 && a[1:0] != 2'b00) bad = 1'b1;
`endif
        w = ref_mem[a[7:2]];
        e.err = 1'b0;
        e.c0  = cyc;
        if (bad) begin
            e.err = 1'b1;
            ref_rdata = 32'd0;
            e.lat = 1;
        end else if (st) begin
            if (f3 == 3'd0) begin
                w[8*a[1:0] +: 8] = wd[7:0];
                e.lat = 3;
            end else if (f3 == 3'd1) begin
                w[16*a[1] +: 16] = wd[15:0];
                e.lat = 3;
            end else begin
                w = wd;
                e.lat = 1;
            end
            ref_mem[a[7:2]] = w;
        end else begin
            b8  = 8'(w >> (8 * a[1:0]));
            h16 = 16'(w >> (16 * a[1]));
            case (f3)
                3'd0:    ref_rdata = {{24{b8[7]}}, b8};
                3'd4:    ref_rdata = {24'd0, b8};
                3'd1:    ref_rdata = {{16{h16[15]}}, h16};
                3'd5:    ref_rdata = {16'd0, h16};
                default: ref_rdata = w;
            endcase
            e.lat = 2;
        end
        e.rdata = ref_rdata;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int s0;
        int l0;
        logic [31:0] old;
        cyc = 0; n_tests = 0; n_fail = 0; st_cnt = 0; ld_cnt = 0;
        last_waddr = 32'd0; last_wdata = 32'd0; ref_rdata = 32'd0;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        bus.req_valid_in = 1'b0; bus.is_store_in = 1'b0; bus.funct3_in = 3'd0;
        bus.addr_in = 32'd0; bus.wdata_in = 32'd0; bus.mem_data_in = 32'd0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, bus.req_ready_out}, 32'd1);
        check("rst_resp", {31'd0, bus.resp_valid_out}, 32'd0);
        check("rst_err", {31'd0, bus.err_out}, 32'd0);
        check("rst_rdata", bus.rdata_out, 32'd0);
        check("rst_ld_en", {31'd0, bus.mem_load_en_out}, 32'd0);
        check("rst_st_en", {31'd0, bus.mem_store_en_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        s0 = st_cnt;
        issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
        drain();
        check("sw_store_cycles", 32'(st_cnt - s0), 32'd1);
        check("sw_waddr", last_waddr, 32'd4);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);

        issue(1'b0, 3'd0, 32'h13, 32'd0);
        issue(1'b0, 3'd4, 32'h13, 32'd0);
        issue(1'b0, 3'd1, 32'h12, 32'd0);
        issue(1'b0, 3'd5, 32'h12, 32'd0);
        issue(1'b0, 3'd0, 32'h10, 32'd0);
        drain();

        s0 = st_cnt;
        issue(1'b1, 3'd0, 32'h11, 32'h00000055);
        drain();
        check("sb_store_cycles", 32'(st_cnt - s0), 32'd1);
        check("sb_merged", last_wdata, 32'hDEAD55EF);
        issue(1'b0, 3'd2, 32'h10, 32'd0);
        issue(1'b1, 3'd1, 32'h12, 32'h00001234);
        drain();
        check("sh_merged", last_wdata, 32'h123455EF);
        issue(1'b0, 3'd2, 32'h10, 32'd0);
        drain();

        s0 = st_cnt; l0 = ld_cnt;
        issue(1'b0, 3'd3, 32'h10, 32'd0);
        issue(1'b1, 3'd4, 32'h10, 32'h11111111);
        issue(1'b0, 3'd6, 32'h10, 32'd0);
        issue(1'b1, 3'd3, 32'h10, 32'h22222222);
        drain();
        check("err_no_store", 32'(st_cnt - s0), 32'd0);
        check("err_no_load", 32'(ld_cnt - l0), 32'd0);

        issue(1'b1, 3'd2, 32'h14, 32'hCAFEF00D);
        drain();
        l0 = ld_cnt;
        issue(1'b0, 3'd2, 32'h16, 32'd0);
        drain();
`ifdef MISALIGN_TRAP_EN
        check("misalign_no_load", 32'(ld_cnt - l0), 32'd0);
`else
        check("misalign_load", 32'(ld_cnt - l0), 32'd1);
`endif
        issue(1'b0, 3'd1, 32'h13, 32'd0);
        issue(1'b0, 3'd5, 32'h15, 32'd0);
        drain();

        old = ref_mem[4];
        s0 = st_cnt;
        issue(1'b1, 3'd0, 32'h11, 32'h000000AA);
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_st_en", {31'd0, bus.mem_store_en_out}, 32'd0);
        check("arst_ld_en", {31'd0, bus.mem_load_en_out}, 32'd0);
        check("arst_ready", {31'd0, bus.req_ready_out}, 32'd1);
        exp_q.delete();
        ref_mem[4] = old;
        ref_rdata = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("arst_no_write", 32'(st_cnt - s0), 32'd0);
        check("arst_mem_kept", mem[4], old);

        issue(1'b0, 3'd2, 32'h10, 32'd0);
        issue(1'b0, 3'd2, 32'h14, 32'd0);
        issue(1'b0, 3'd0, 32'h12, 32'd0);
        issue(1'b0, 3'd5, 32'h16, 32'd0);
        drain();

        for (int i = 0; i < 30; i++) begin
            issue(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  32'($urandom_range(0, 255)), $urandom);
        end
        drain();
        for (int i = 0; i < 64; i++) begin
            if (mem[i] !== ref_mem[i]) check("final_mem", mem[i], ref_mem[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500000");
        $fatal(1, "timeout");
    end

endmodule
